// File: rtl/inj_sched_if.sv
// inj_sched_if: requester-side and router-side signals of the local injection scheduler.
// slave is the scheduler's view; master is the view of whatever drives the requesters and the router.
interface inj_sched_if #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 144
);
    logic                   inj_en;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FLIT_W-1:0] req_flit;
    logic [NREQ-1:0]        req_ready;
    logic [FLIT_W-1:0]      portl0_ci;
    logic [FLIT_W-1:0]      portl1_ci;
    logic                   portl0_ack;
    logic                   portl1_ack;
    logic [1:0]             slot_busy;

    modport master (
        output inj_en, req_valid, req_flit, portl0_ack, portl1_ack,
        input  req_ready, portl0_ci, portl1_ci, slot_busy
    );

    modport slave (
        input  inj_en, req_valid, req_flit, portl0_ack, portl1_ack,
        output req_ready, portl0_ci, portl1_ci, slot_busy
    );
endinterface

// File: rtl/inj_sched.sv
// inj_sched: shares the two router injection ports between NREQ requesters, one held flit each, round-robin.
// Define INJ_STATS_EN to add the inj_cnt/stall_cnt statistics outputs.
module inj_sched #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 144,
    parameter int IDXW   = 2
) (
    input  logic        clk,
    input  logic        rst,
    inj_sched_if.slave  bus
`ifdef INJ_STATS_EN
    ,
    output logic [31:0] inj_cnt,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic {IDLE, OFFER} slot_st_e;

    slot_st_e          st_q   [2];
    slot_st_e          st_d   [2];
    logic [IDXW-1:0]   own_q  [2];
    logic [IDXW-1:0]   own_d  [2];
    logic [FLIT_W-1:0] flit_q [2];
    logic [FLIT_W-1:0] flit_d [2];
    logic [FLIT_W-1:0] hold_q [NREQ];
    logic [FLIT_W-1:0] hold_d [NREQ];
    logic [NREQ-1:0]   hold_v_q, hold_v_d, pend, pend1, clr, load;
    logic [IDXW-1:0]   rr_q, rr_d, g0, g1;
    logic [1:0]        ack, retire, elig, gnt;
    logic [IDXW:0]     p0, p1;

    // {found, index} of the set bit in v closest to start going upwards with wrap
    function automatic logic [IDXW:0] pick(input logic [NREQ-1:0] v, input int start);
        logic [IDXW:0] r;
        int best, d;
        r    = '0;
        best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + NREQ - start) % NREQ;
            if (v[j] && d < best) begin
                best = d;
                r    = {1'b1, IDXW'(j)};
            end
        end
        return r;
    endfunction

    always_comb begin
        ack  = {bus.portl1_ack, bus.portl0_ack};
        load = bus.req_valid & ~hold_v_q;
        for (int s = 0; s < 2; s++) begin
            retire[s] = (st_q[s] == OFFER) && ack[s];
            elig[s]   = bus.inj_en && ((st_q[s] == IDLE) || ack[s]);
        end
        for (int i = 0; i < NREQ; i++) begin
            clr[i]  = (retire[0] && own_q[0] == IDXW'(i)) || (retire[1] && own_q[1] == IDXW'(i));
            pend[i] = hold_v_q[i] && !(st_q[0] == OFFER && own_q[0] == IDXW'(i))
                                  && !(st_q[1] == OFFER && own_q[1] == IDXW'(i));
        end
        p0     = pick(pend, int'(rr_q));
        gnt[0] = elig[0] && p0[IDXW];
        g0     = p0[IDXW-1:0];
        // slot 1 continues the search just past slot 0's grant so no register is claimed twice
        for (int i = 0; i < NREQ; i++)
            pend1[i] = pend[i] && !(gnt[0] && g0 == IDXW'(i));
        p1     = pick(pend1, gnt[0] ? int'(g0) + 1 : int'(rr_q));
        gnt[1] = elig[1] && p1[IDXW];
        g1     = p1[IDXW-1:0];
        rr_d   = gnt[1] ? IDXW'((int'(g1) + 1) % NREQ) :
                 gnt[0] ? IDXW'((int'(g0) + 1) % NREQ) : rr_q;
        hold_v_d = (hold_v_q & ~clr) | load;
        for (int i = 0; i < NREQ; i++)
            hold_d[i] = load[i] ? bus.req_flit[i*FLIT_W +: FLIT_W] : hold_q[i];
        st_d[0]   = gnt[0] ? OFFER : (retire[0] ? IDLE : st_q[0]);
        own_d[0]  = gnt[0] ? g0 : own_q[0];
        flit_d[0] = gnt[0] ? hold_q[g0] : flit_q[0];
        st_d[1]   = gnt[1] ? OFFER : (retire[1] ? IDLE : st_q[1]);
        own_d[1]  = gnt[1] ? g1 : own_q[1];
        flit_d[1] = gnt[1] ? hold_q[g1] : flit_q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v_q <= '0;
            hold_q   <= '{default: '0};
            st_q     <= '{default: IDLE};
            own_q    <= '{default: '0};
            flit_q   <= '{default: '0};
            rr_q     <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            st_q     <= st_d;
            own_q    <= own_d;
            flit_q   <= flit_d;
            rr_q     <= rr_d;
        end
    end

    assign bus.req_ready = ~hold_v_q;
    assign bus.portl0_ci = (st_q[0] == OFFER) ? flit_q[0] : '0;
    assign bus.portl1_ci = (st_q[1] == OFFER) ? flit_q[1] : '0;
    assign bus.slot_busy = {st_q[1] == OFFER, st_q[0] == OFFER};

`ifdef INJ_STATS_EN
    logic [31:0] inj_cnt_q, inj_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        inj_cnt_d   = inj_cnt_q + 32'(retire[0]) + 32'(retire[1]);
        stall_cnt_d = stall_cnt_q + 32'((st_q[0] == OFFER && !ack[0]) || (st_q[1] == OFFER && !ack[1]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            inj_cnt_q   <= inj_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign inj_cnt   = inj_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_inj_sched.sv
// tb_inj_sched: directed vector table plus hand-written reset, fairness and hold sequences for inj_sched.
module tb_inj_sched;
    localparam int NREQ = 4;
    localparam int FW   = 144;

    typedef struct {
        logic            en;
        logic [3:0]      v;
        logic [63:0]     t;
        logic [1:0]      ack;
        logic [15:0]     e0;
        logic [15:0]     e1;
        logic [1:0]      eb;
        logic [3:0]      er;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           nvec = 0;
    int           nfail = 0;
    logic [293:0] obs;

    inj_sched_if #(.NREQ(NREQ), .FLIT_W(FW)) bus ();

`ifdef INJ_STATS_EN
    logic [31:0] inj_cnt, stall_cnt;
    logic [31:0] exp_inj, exp_stall;
`endif

    inj_sched #(.NREQ(NREQ), .FLIT_W(FW), .IDXW(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INJ_STATS_EN
        ,
        .inj_cnt(inj_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {bus.portl0_ci, bus.portl1_ci, bus.slot_busy, bus.req_ready};

    function automatic logic [FW-1:0] flit(input logic [15:0] t);
        return {9{t}};
    endfunction

    function automatic logic [15:0] tag(input int i, input int n);
        return 16'(256 * (i + 1) + n + 1);
    endfunction

    function automatic logic [293:0] mk(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [1:0] eb, input logic [3:0] er);
        return {flit(e0), flit(e1), eb, er};
    endfunction

    function automatic vec_t mkv(input logic en, input logic [3:0] v, input logic [63:0] t,
                                 input logic [1:0] ack, input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [1:0] eb, input logic [3:0] er);
        vec_t r;
        r.en = en; r.v = v; r.t = t; r.ack = ack;
        r.e0 = e0; r.e1 = e1; r.eb = eb; r.er = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [293:0] act, input logic [293:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] v, input logic [63:0] t, input logic [1:0] ack);
        bus.inj_en    = en;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++)
            bus.req_flit[i*FW +: FW] = flit(t[i*16 +: 16]);
        bus.portl0_ack = ack[0];
        bus.portl1_ack = ack[1];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // all requesters stream counter-tagged flits; hold=1 keeps portl1 unacked
    task automatic stream(input logic [1:0] ack, input int n, input bit hold);
        int           cnt [NREQ];
        logic [3:0]   rdy;
        logic [63:0]  t;
        logic [15:0]  e0, e1;
        logic [1:0]   eb;
        logic [293:0] x;
        int           k, r;
        cnt = '{default: 0};
        for (int e = 1; e <= n; e++) begin
            for (int i = 0; i < NREQ; i++)
                t[i*16 +: 16] = tag(i, cnt[i]);
            drive(1'b1, 4'b1111, t, ack);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (rdy[i]) cnt[i]++;
            if (hold) begin
                k  = e - 3;
                r  = (k % 3 == 0) ? 2 : (k % 3 == 1) ? 3 : 0;
                e0 = (e == 1) ? 16'h0 : (e == 2) ? tag(0, 0) : tag(r, k / 3 + ((r == 0) ? 1 : 0));
                e1 = (e == 1) ? 16'h0 : tag(1, 0);
                eb = (e == 1) ? 2'b00 : 2'b11;
            end else begin
                e0 = (e % 3 == 1) ? 16'h0 : (e % 3 == 2) ? tag(0, e / 3) : tag(2, e / 3 - 1);
                e1 = (e % 3 == 1) ? 16'h0 : (e % 3 == 2) ? tag(1, e / 3) : tag(3, e / 3 - 1);
                eb = (e % 3 == 1) ? 2'b00 : 2'b11;
            end
            x      = obs;
            x[3:0] = '0;
            check($sformatf("%s%0d", hold ? "hold" : "rr", e), x, mk(e0, e1, eb, 4'b0000));
        end
    endtask

    initial begin
        vec_t vecs [24];
`ifdef INJ_STATS_EN
        logic [1:0] peb;
`endif
        vecs[0]  = mkv(1'b1, 4'b0100, 64'h0000_1857_0000_0000, 2'b00, 16'h0,    16'h0,    2'b00, 4'b1011);
        vecs[1]  = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h1857, 16'h0,    2'b01, 4'b1011);
        vecs[2]  = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h1857, 16'h0,    2'b01, 4'b1011);
        vecs[3]  = mkv(1'b1, 4'b0000, '0,                      2'b11, 16'h0,    16'h0,    2'b00, 4'b1111);
        vecs[4]  = mkv(1'b1, 4'b1000, 64'h0003_0000_0000_0000, 2'b00, 16'h0,    16'h0,    2'b00, 4'b0111);
        vecs[5]  = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h0003, 16'h0,    2'b01, 4'b0111);
        vecs[6]  = mkv(1'b1, 4'b0000, '0,                      2'b01, 16'h0,    16'h0,    2'b00, 4'b1111);
        vecs[7]  = mkv(1'b1, 4'b0011, 64'h0000_0000_00B1_00A0, 2'b00, 16'h0,    16'h0,    2'b00, 4'b1100);
        vecs[8]  = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h00A0, 16'h00B1, 2'b11, 4'b1100);
        vecs[9]  = mkv(1'b1, 4'b0000, '0,                      2'b11, 16'h0,    16'h0,    2'b00, 4'b1111);
        vecs[10] = mkv(1'b1, 4'b0111, 64'h0000_00C2_00C1_00C0, 2'b00, 16'h0,    16'h0,    2'b00, 4'b1000);
        vecs[11] = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h00C2, 16'h00C0, 2'b11, 4'b1000);
        vecs[12] = mkv(1'b1, 4'b0000, '0,                      2'b11, 16'h00C1, 16'h0,    2'b01, 4'b1101);
        vecs[13] = mkv(1'b1, 4'b0000, '0,                      2'b01, 16'h0,    16'h0,    2'b00, 4'b1111);
        vecs[14] = mkv(1'b0, 4'b1001, 64'h00D3_0000_0000_00D0, 2'b00, 16'h0,    16'h0,    2'b00, 4'b0110);
        vecs[15] = mkv(1'b0, 4'b0000, '0,                      2'b00, 16'h0,    16'h0,    2'b00, 4'b0110);
        vecs[16] = mkv(1'b1, 4'b0000, '0,                      2'b00, 16'h00D3, 16'h00D0, 2'b11, 4'b0110);
        vecs[17] = mkv(1'b0, 4'b0000, '0,                      2'b11, 16'h0,    16'h0,    2'b00, 4'b1111);
        vecs[18] = mkv(1'b1, 4'b1111, 64'h00E3_00E2_00E1_00E0, 2'b00, 16'h0,    16'h0,    2'b00, 4'b0000);
        vecs[19] = mkv(1'b1, 4'b1111, 64'h00E3_00E2_00E1_00E0, 2'b00, 16'h00E1, 16'h00E2, 2'b11, 4'b0000);
        vecs[20] = mkv(1'b1, 4'b0000, '0,                      2'b01, 16'h00E3, 16'h00E2, 2'b11, 4'b0010);
        vecs[21] = mkv(1'b1, 4'b0000, '0,                      2'b01, 16'h00E0, 16'h00E2, 2'b11, 4'b1010);
        vecs[22] = mkv(1'b1, 4'b0000, '0,                      2'b01, 16'h0,    16'h00E2, 2'b10, 4'b1011);
        vecs[23] = mkv(1'b1, 4'b0000, '0,                      2'b10, 16'h0,    16'h0,    2'b00, 4'b1111);

        #2;
        do_reset();
        check("reset", obs, mk(16'h0, 16'h0, 2'b00, 4'b1111));
`ifdef INJ_STATS_EN
        exp_inj   = '0;
        exp_stall = '0;
        peb       = 2'b00;
`endif
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].en, vecs[i].v, vecs[i].t, vecs[i].ack);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs, mk(vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].er));
`ifdef INJ_STATS_EN
            exp_inj   = exp_inj + 32'($countones(peb & vecs[i].ack));
            exp_stall = exp_stall + 32'(|(peb & ~vecs[i].ack));
            peb       = vecs[i].eb;
`endif
        end
`ifdef INJ_STATS_EN
        check("inj_cnt", 294'(inj_cnt), 294'(exp_inj));
        check("stall_cnt", 294'(stall_cnt), 294'(exp_stall));
`endif

        // asynchronous reset while slot 0 offers flit A: nothing survives it
        do_reset();
        drive(1'b1, 4'b0001, 64'h0000_0000_0000_0AAA, 2'b00);
        @(posedge clk);
        #1;
        drive(1'b1, 4'b0000, '0, 2'b00);
        @(posedge clk);
        #1;
        check("pre_reset_offer", obs, mk(16'h0AAA, 16'h0, 2'b01, 4'b1110));
        #2 rst = 1'b0;
        #1 check("async_reset", obs, mk(16'h0, 16'h0, 2'b00, 4'b1111));
`ifdef INJ_STATS_EN
        check("stats_reset", 294'({inj_cnt, stall_cnt}), '0);
`endif
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d", c), obs, mk(16'h0, 16'h0, 2'b00, 4'b1111));
        end

        do_reset();
        stream(2'b11, 9, 1'b0);
        do_reset();
        stream(2'b01, 22, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/inj_sched.md
Name: inj_sched

Overview:
- Local injection scheduler in front of nodeRouter.
- Shares the router's two local injection ports (portl0/portl1) between NREQ local requesters (core, L1, L2 slice, ...).
- Buffers one flit per requester and assigns pending flits to free injection slots in round-robin order.
- Holds each offered flit on its port until the router acks it.

Parameters:
- NREQ, 4, number of requesters, 1..8.
- FLIT_W, 144, flit width; equals the `control_w width.
- IDXW, 2, requester index width; must be at least clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inj_en  in  1  1 = slots may load new flits; 0 = throttle (in-flight offers continue).
- req_valid  in  NREQ  requester i presents a flit.
- req_flit  in  NREQ*FLIT_W  packed flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  out  NREQ  holding register i empty; registered.
- portl0_ci  out  FLIT_W  flit to router local port 0; all-zero = no flit.
- portl1_ci  out  FLIT_W  flit to router local port 1; all-zero = no flit.
- portl0_ack  in  1  router accepted portl0_ci this cycle.
- portl1_ack  in  1  router accepted portl1_ci this cycle.
- slot_busy  out  2  bit s = slot s in OFFER.

Behaviour:
- Reset (rst=0, asynchronous):
  - All holding registers and slots invalid.
  - rr_ptr=0.
  - portl0_ci=portl1_ci=0, slot_busy=0, req_ready=all ones.
  - Reset mid-operation discards all held and offered flits; no ack is expected after reset.
- Holding registers:
  - Register i loads req_flit[i] on an edge where req_valid[i] && req_ready[i].
  - req_ready[i] = ~hold_v[i], registered.
  - req_valid without ready is ignored; the requester must hold the flit.
- Holding register i is pending when hold_v[i]=1 and it is not owned by either slot.
- Per-slot FSM, slot s in {0,1}:
  - IDLE: portl{s}_ci=0. At an edge with inj_en=1 and at least one pending register, the slot captures owner index and a flit copy, then goes to OFFER.
  - OFFER: portl{s}_ci = captured flit; slot_busy[s]=1.
    - On an edge with portl{s}_ack=1, clear hold_v[owner].
    - If inj_en=1 and another register is pending at that same edge, reload directly (stay in OFFER, new owner); otherwise go to IDLE.
    - Without ack, the flit and owner stay stable indefinitely.
- Grant order:
  - Search starts at rr_ptr and wraps mod NREQ.
  - Slot 0 picks first; slot 1 picks the next pending index after slot 0's pick in the same cycle.
  - A register is never owned by both slots.
  - rr_ptr := (last granted index + 1) mod NREQ; it is unchanged if nothing is granted.
  - NREQ=1: only slot 0 is ever used.
- Latency:
  - Flit accepted at edge t appears on a port from edge t+1 at the earliest.
  - After an ack at edge t, req_ready[owner] is high after t; the next flit from that requester is accepted at t+1 and offered at t+2 (one bubble per requester).
- Boundary cases:
  - Ack on an IDLE slot is ignored.
  - Acks on both slots at the same edge free both owners.
  - inj_en=0 with both slots OFFER: acks still retire flits; slots then go IDLE.
  - All holding registers full: req_ready=0.
  - Flit value all-zero is illegal input (it means idle); behaviour is undefined.

Optional Feature:
- Macro INJ_STATS_EN.
- Defined, adds:
  - Output inj_cnt, 32 bits: increments per ack on an OFFER slot, +2 when both slots are acked.
  - Output stall_cnt, 32 bits: increments each cycle at least one slot is OFFER without ack.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Reset: drive rst=0 mid-offer with slot0 holding flit A.
  - Outputs immediately 0, req_ready=4'b1111; after release, no re-offer of A.
- Single flit: req_valid=4'b0100, flit 0x...1857, inj_en=1.
  - portl0_ci=flit one cycle later, slot_busy=2'b01.
  - Ack 2 cycles later -> portl0_ci=0 next cycle, req_ready[2] high.
- Dual slot: requesters 0 and 1 load together with rr_ptr=0.
  - Slot0 owns req0, slot1 owns req1.
  - Simultaneous acks -> both ready next cycle, rr_ptr=2.
- Round-robin fairness: all 4 requesters continuously valid, acks every cycle on both ports.
  - Grant order 0,1 | 2,3 | 0,1; no requester waits more than 2 grant rounds.
- Hold without ack: portl1_ack=0 for 20 cycles.
  - portl1_ci unchanged, owner unchanged; other requesters continue via slot0.
- Throttle: inj_en=0 with 2 pending flits.
  - No slot leaves IDLE; set inj_en=1 -> both offered next cycle.
  - With INJ_STATS_EN: inj_cnt matches the ack count and stall_cnt matches the unacked OFFER cycles.
